// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data memory controller and its clear sequencer.
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_clear_seq.sv
// dmem_clear_seq: sweeps every word of the data memory to INIT_VAL on request.
`default_nettype none

module dmem_clear_seq
  import dmem_pkg::*;
#(
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         ClearReq,
  output logic         Busy,
  output logic         ClearDone,
  output logic         ClearWe,
  output logic [A-1:0] ClearAddr
);

  // The extra counter bit lets the last index be compared without wrapping.
  localparam logic [A:0] LAST_IDX = {1'b0, {A{1'b1}}};
  localparam logic [A:0] CNT_ONE  = {{A{1'b0}}, 1'b1};

  clr_state_t   state_q;
  logic [A:0]   cnt_q;
  logic         busy_q;
  logic         done_q;
  logic         we_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (ClearReq) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            we_q    <= 1'b1;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_IDX) begin
            state_q <= DONE;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = busy_q;
  assign ClearDone = done_q;
  assign ClearWe   = we_q;
  assign ClearAddr = cnt_q[A-1:0];

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: single-port data memory with request/ready handshake,
// selectable read latency and a hardware clear sweep.
`default_nettype none

module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int             W         = 8,
  parameter int             A         = 8,
  parameter int             RD_LAT    = 0,
  parameter logic [W-1:0]   INIT_VAL  = '0,
  parameter                 INIT_FILE = ""
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         Req,
  input  logic         WriteEn,
  input  logic [A-1:0] DataAddress,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] DataOut,
  output logic         RdValid,
  output logic         Ready,
  input  logic         ClearReq,
  output logic         Busy,
  output logic         ClearDone
);

  localparam int DEPTH = 2 ** A;

  logic [W-1:0] core_q [DEPTH];

  logic         clear_we;
  logic [A-1:0] clear_addr;
  logic         accept;
  logic         user_we;
  logic         rd_accept;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_din;
  logic [W-1:0] rd_word;

  dmem_clear_seq #(
    .A (A)
  ) u_clear_seq (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .ClearReq  (ClearReq),
    .Busy      (Busy),
    .ClearDone (ClearDone),
    .ClearWe   (clear_we),
    .ClearAddr (clear_addr)
  );

  // Busy covers every non-IDLE state, so this is exactly IDLE && !ClearReq.
  assign Ready     = !Busy && !ClearReq;
  assign accept    = Req && Ready;
  assign user_we   = accept && WriteEn;
  assign rd_accept = accept && !WriteEn;

  assign mem_we   = clear_we || user_we;
  assign mem_addr = clear_we ? clear_addr : DataAddress;
  assign mem_din  = clear_we ? INIT_VAL : DataIn;

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      core_q[mem_addr] <= mem_din;
    end
  end

  assign rd_word = core_q[DataAddress];

  if (RD_LAT == 0) begin : g_comb_rd
    assign DataOut = rd_word;
    assign RdValid = rd_accept;
  end else begin : g_reg_rd
    logic [W-1:0] dout_q;
    logic         rv_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        rv_q <= rd_accept;
        if (rd_accept) begin
          dout_q <= rd_word;
        end
      end
    end

    assign DataOut = dout_q;
    assign RdValid = rv_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench for data_mem_ctrl (two A=8 ports, one A=4 clear port).
`default_nettype none

module tb_data_mem_ctrl;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  // Group X: shared stimulus into an RD_LAT=0 and an RD_LAT=1 instance, A=8.
  logic       rstx_n, reqx, wex;
  logic [7:0] addrx, dinx;
  logic       clrx;
  logic [7:0] dout0, dout1;
  logic       rv0, rdy0, busy0, cd0;
  logic       rv1, rdy1, busy1, cd1;

  // Clear-sweep instance: A=4, RD_LAT=0, INIT_VAL=0x5A.
  logic       rst2_n, req2, we2, clr2;
  logic [3:0] addr2;
  logic [7:0] din2, dout2;
  logic       rv2, rdy2, busy2, cd2;

  data_mem_ctrl #(.W(8), .A(8), .RD_LAT(0), .INIT_VAL(8'h00)) u_dut0 (
    .Clk(Clk), .Reset_n(rstx_n), .Req(reqx), .WriteEn(wex), .DataAddress(addrx),
    .DataIn(dinx), .DataOut(dout0), .RdValid(rv0), .Ready(rdy0), .ClearReq(clrx),
    .Busy(busy0), .ClearDone(cd0));

  data_mem_ctrl #(.W(8), .A(8), .RD_LAT(1), .INIT_VAL(8'h00)) u_dut1 (
    .Clk(Clk), .Reset_n(rstx_n), .Req(reqx), .WriteEn(wex), .DataAddress(addrx),
    .DataIn(dinx), .DataOut(dout1), .RdValid(rv1), .Ready(rdy1), .ClearReq(clrx),
    .Busy(busy1), .ClearDone(cd1));

  data_mem_ctrl #(.W(8), .A(4), .RD_LAT(0), .INIT_VAL(8'h5A)) u_dut2 (
    .Clk(Clk), .Reset_n(rst2_n), .Req(req2), .WriteEn(we2), .DataAddress(addr2),
    .DataIn(din2), .DataOut(dout2), .RdValid(rv2), .Ready(rdy2), .ClearReq(clr2),
    .Busy(busy2), .ClearDone(cd2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [7:0] data);
    vectors++;
    miscompares++;
    $display("FAIL %s: got RdValid=1 data %0h, expected no read response", name, data);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a read result.
  always @(negedge Clk) begin
    if (rv0 === 1'b1) begin
      if (q0.size() == 0) unexpected("rd_lat0", dout0);
      else chk("rd_lat0_data", {24'h0, dout0}, {24'h0, q0.pop_front()});
    end
    if (rv1 === 1'b1) begin
      if (q1.size() == 0) unexpected("rd_lat1", dout1);
      else chk("rd_lat1_data", {24'h0, dout1}, {24'h0, q1.pop_front()});
    end
    if (rv2 === 1'b1) begin
      if (q2.size() == 0) unexpected("rd_clr", dout2);
      else chk("rd_clr_data", {24'h0, dout2}, {24'h0, q2.pop_front()});
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wrx(input logic [7:0] a, input logic [7:0] d);
    reqx = 1'b1; wex = 1'b1; addrx = a; dinx = d;
    tick();
    reqx = 1'b0; wex = 1'b0;
  endtask

  task automatic rdx(input logic [7:0] a, input logic [7:0] exp);
    reqx = 1'b1; wex = 1'b0; addrx = a;
    q0.push_back(exp);
    q1.push_back(exp);
    tick();
    reqx = 1'b0;
  endtask

  task automatic wr2(input logic [3:0] a, input logic [7:0] d);
    req2 = 1'b1; we2 = 1'b1; addr2 = a; din2 = d;
    tick();
    req2 = 1'b0; we2 = 1'b0;
  endtask

  task automatic rd2(input logic [3:0] a, input logic [7:0] exp);
    req2 = 1'b1; we2 = 1'b0; addr2 = a;
    q2.push_back(exp);
    tick();
    req2 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int done_at;
    int done_cnt;

    rstx_n = 1'b0; reqx = 1'b0; wex = 1'b0; addrx = '0; dinx = '0; clrx = 1'b0;
    rst2_n = 1'b0; req2 = 1'b0; we2 = 1'b0; addr2 = '0; din2 = '0; clr2 = 1'b0;
    tick();
    tick();

    chk("rst_rv0", {31'h0, rv0}, 32'h0);
    chk("rst_rv1", {31'h0, rv1}, 32'h0);
    chk("rst_dout1", {24'h0, dout1}, 32'h0);
    chk("rst_busy0", {31'h0, busy0}, 32'h0);
    chk("rst_cd0", {31'h0, cd0}, 32'h0);
    chk("rst_busy2", {31'h0, busy2}, 32'h0);
    chk("rst_cd2", {31'h0, cd2}, 32'h0);
    rstx_n = 1'b1;
    rst2_n = 1'b1;
    #1;
    chk("rst_ready0", {31'h0, rdy0}, 32'h1);
    chk("rst_ready2", {31'h0, rdy2}, 32'h1);
    tick();

    // Write then read back-to-back: new data must be visible next cycle.
    wrx(8'h10, 8'hA5);
    rdx(8'h10, 8'hA5);
    tick();
    tick();
    chk("lat1_hold", {24'h0, dout1}, 32'hA5);
    chk("lat1_rv_pulse", {31'h0, rv1}, 32'h0);
    wrx(8'h00, 8'h11);
    wrx(8'hFF, 8'hEE);
    rdx(8'h00, 8'h11);
    rdx(8'hFF, 8'hEE);
    wrx(8'h10, 8'h5C);
    rdx(8'h10, 8'h5C);
    rdx(8'h00, 8'h11);
    tick();
    tick();
    chk("lat1_hold2", {24'h0, dout1}, 32'h11);

    // Clear sweep: 16 CLEAR cycles plus one DONE cycle.
    for (int i = 0; i < 16; i++) wr2(i[3:0], 8'h30 + i[7:0]);
    rd2(4'd7, 8'h37);
    clr2 = 1'b1;
    #1;
    chk("ready_with_clearreq", {31'h0, rdy2}, 32'h0);
    tick();
    clr2 = 1'b0;
    n = 0; done_at = -1; done_cnt = 0;
    while (busy2 && n < 40) begin
      if (cd2) begin
        done_cnt++;
        done_at = n;
      end
      tick();
      n++;
    end
    chk("busy_cycles", n, 32'd17);
    chk("done_cycle", done_at, 32'd16);
    chk("done_pulses", done_cnt, 32'd1);
    for (int i = 0; i < 16; i++) rd2(i[3:0], 8'h5A);

    // ClearReq beats a same-cycle write; requests during the sweep are refused.
    wr2(4'd0, 8'hB0);
    wr2(4'd2, 8'hB2);
    req2 = 1'b1; we2 = 1'b1; addr2 = 4'd2; din2 = 8'h3C; clr2 = 1'b1;
    #1;
    chk("ready_clr_vs_req", {31'h0, rdy2}, 32'h0);
    tick();
    clr2 = 1'b0;
    n = 0;
    while (busy2 && n < 40) begin
      req2 = 1'b1;
      if (n[0]) begin
        we2 = 1'b0; addr2 = 4'd1;
      end else begin
        we2 = 1'b1; addr2 = 4'd0; din2 = 8'h77;
      end
      #1;
      chk("ready_while_busy", {31'h0, rdy2}, 32'h0);
      tick();
      n++;
    end
    req2 = 1'b0; we2 = 1'b0;
    chk("busy_cycles2", n, 32'd17);
    rd2(4'd2, 8'h5A);
    rd2(4'd0, 8'h5A);
    rd2(4'd1, 8'h5A);

    // Reset in sweep cycle 5: words 0-4 cleared, rest keep old data.
    for (int i = 0; i < 16; i++) wr2(i[3:0], 8'hC0 + i[7:0]);
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    repeat (5) tick();
    rst2_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy2}, 32'h0);
    chk("abort_cd", {31'h0, cd2}, 32'h0);
    tick();
    rst2_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cd2) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 32'd0);
    for (int i = 0; i < 16; i++) begin
      if (i < 5) rd2(i[3:0], 8'h5A);
      else rd2(i[3:0], 8'hC0 + i[7:0]);
    end

    repeat (3) tick();
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
